// File: rtl/baej_isa_pkg.sv
// ISA constants shared by fetch and decode: opcode field position, opcode values
// and the set of opcodes that carry a second (immediate) word.
package baej_isa_pkg;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;

    localparam opcode_t OPC_NOP = 4'b0000;
    localparam opcode_t OPC_LDI = 4'b0001;
    localparam opcode_t OPC_ADD = 4'b0010;
    localparam opcode_t OPC_SUB = 4'b0011;
    localparam opcode_t OPC_AND = 4'b0100;
    localparam opcode_t OPC_OR  = 4'b0101;
    localparam opcode_t OPC_LD  = 4'b0110;
    localparam opcode_t OPC_ST  = 4'b0111;
    localparam opcode_t OPC_JMP = 4'b1000;
    localparam opcode_t OPC_BEQ = 4'b1001;

    // Only ldi is followed by an immediate word today.
    function automatic logic is_two_word(input opcode_t opc);
        return opc == OPC_LDI;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {word, pc} pairs: one push and up to two pops per clock,
// with the head and head+1 entries visible combinationally for instruction pairing.
module fetch_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_word,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [1:0]        pop_n,
    output logic [CW-1:0]     count,
    output logic [DATA_W-1:0] head_word,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head1_word
);

    logic [DATA_W-1:0] word_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr1;
    logic [CW-1:0]     count_reg;
    logic              do_push;

    // A flush wins over a push arriving in the same cycle.
    assign do_push = push && !flush;
    assign rd_ptr1 = rd_ptr_reg + PW'(1);

    always_ff @(posedge clk) begin
        if (do_push) begin
            word_mem[wr_ptr_reg] <= push_word;
            pc_mem[wr_ptr_reg]   <= push_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            rd_ptr_reg <= rd_ptr_reg + PW'(pop_n);
            count_reg  <= count_reg + CW'(do_push) - CW'(pop_n);
        end
    end

    assign count      = count_reg;
    assign head_word  = word_mem[rd_ptr_reg];
    assign head_pc    = pc_mem[rd_ptr_reg];
    assign head1_word = word_mem[rd_ptr1];

    // The fetch credit check must make a push into a full FIFO impossible.
    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n || flush)
        !(do_push && pop_n == 2'd0 && count_reg == CW'(DEPTH)));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: streams words from pc into a prefetch FIFO, pairs
// two-word instructions and hands bundles to decode over a valid/ready handshake.
module instr_fetch_unit
    import baej_isa_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 16,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_word,
    output logic [DATA_W-1:0] instr_imm,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_two_word
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_C = FIFO_DEPTH[CW:0];

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] issue_pc_reg;
    logic              inflight_reg;
    logic              squash_reg;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] head_word;
    logic [DATA_W-1:0] head1_word;
    logic [ADDR_W-1:0] head_pc;
    logic              issue;
    logic              push;
    logic              head_two;
    logic              bundle_ok;
    logic              valid_int;
    logic              fire;
    logic [1:0]        pop_n;

    // Credit: words already buffered plus the one in flight must leave room.
    assign issue = rst_n && fetch_en && !redirect &&
                   (({1'b0, fifo_count} + {{CW{1'b0}}, inflight_reg}) < DEPTH_C);
    assign mem_rd   = issue;
    assign mem_addr = pc_reg;

    assign push      = inflight_reg && !squash_reg;
    assign head_two  = is_two_word(head_word[OPC_MSB:OPC_LSB]);
    assign bundle_ok = head_two ? (fifo_count >= CW'(2)) : (fifo_count >= CW'(1));
    assign valid_int = rst_n && !redirect && bundle_ok;
    assign fire      = valid_int && instr_ready;
    assign pop_n     = !fire ? 2'd0 : (head_two ? 2'd2 : 2'd1);

    assign instr_valid    = valid_int;
    assign instr_word     = valid_int ? head_word : '0;
    assign instr_pc       = valid_int ? head_pc : '0;
    assign instr_two_word = valid_int && head_two;
    assign instr_imm      = (valid_int && head_two) ? head1_word : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            issue_pc_reg <= '0;
            inflight_reg <= 1'b0;
            squash_reg   <= 1'b0;
        end else begin
            inflight_reg <= issue;
            squash_reg   <= redirect && inflight_reg;
            if (issue) begin
                issue_pc_reg <= pc_reg;
            end
            if (redirect) begin
                pc_reg <= redirect_pc;
            end else if (issue) begin
                pc_reg <= pc_reg + ADDR_W'(1);
            end
        end
    end

    fetch_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (push),
        .push_word  (mem_rdata),
        .push_pc    (issue_pc_reg),
        .pop_n      (pop_n),
        .count      (fifo_count),
        .head_word  (head_word),
        .head_pc    (head_pc),
        .head1_word (head1_word)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed corner sequences, a table of redirect
// targets, and a randomized run checked by a program-order scoreboard.
module tb_instr_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_word;
    logic [15:0] instr_imm;
    logic [15:0] instr_pc;
    logic        instr_two_word;

    logic [15:0] mem [0:65535];

    int n_pass   = 0;
    int n_total  = 0;
    int n_accept = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .FIFO_DEPTH (4),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_rdata      (mem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_word     (instr_word),
        .instr_imm      (instr_imm),
        .instr_pc       (instr_pc),
        .instr_two_word (instr_two_word)
    );

    // Memory block model: registered read, data valid the cycle after mem_rd.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Scoreboard: accepted bundles must walk memory in program order from the
    // last reset/redirect target; a stalled bundle must not change.
    logic [15:0] exp_pc;
    logic        hold_v;
    logic [48:0] hold_b;
    always @(negedge clk) begin
        logic [15:0] w;
        logic [15:0] im;
        logic        tw;
        if (!rst_n) begin
            exp_pc = RESET_PC;
            hold_v = 1'b0;
        end else begin
            if (redirect)
                check("redirect_blocks_valid", 64'(instr_valid), 64'(0));
            else if (hold_v)
                check("stall_stable", 64'({instr_valid, instr_pc, instr_word, instr_imm, instr_two_word}),
                      64'({1'b1, hold_b}));
            if (!instr_valid) begin
                check("idle_zero", 64'({instr_pc, instr_word, instr_imm, instr_two_word}), 64'(0));
            end else if (instr_ready) begin
                w  = mem[exp_pc];
                tw = (w[15:12] == 4'b0001);
                im = tw ? mem[16'(exp_pc + 16'd1)] : 16'h0000;
                check("bundle", 64'({instr_pc, instr_word, instr_imm, instr_two_word}),
                      64'({exp_pc, w, im, tw}));
                exp_pc = exp_pc + (tw ? 16'd2 : 16'd1);
                n_accept++;
            end
            hold_v = instr_valid && !instr_ready;
            hold_b = {instr_pc, instr_word, instr_imm, instr_two_word};
            if (redirect) begin
                exp_pc = redirect_pc;
                hold_v = 1'b0;
            end
        end
    end

    typedef struct packed {
        logic [15:0] target;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] exp_imm;
        logic        exp_two;
        logic [15:0] next_pc;
    } row_t;

    row_t rows [6];

    initial begin
        logic [3:0]  op;
        logic [15:0] t1;
        int          nrd;
        int          acc0;
        bit          ok;
        bit          found;

        rows[0] = '{16'h0100, 16'h0010, 16'h2000, 16'h0000, 1'b0, 16'h0101};
        rows[1] = '{16'h0200, 16'h1010, 16'h000A, 16'h000A, 1'b1, 16'h0202};
        rows[2] = '{16'hFFFF, 16'h1ABC, 16'h1234, 16'h1234, 1'b1, 16'h0001};
        rows[3] = '{16'hFFFE, 16'h1000, 16'h0055, 16'h0055, 1'b1, 16'h0000};
        rows[4] = '{16'h7FFF, 16'hF123, 16'h1111, 16'h0000, 1'b0, 16'h8000};
        rows[5] = '{16'h0040, 16'h0001, 16'h1FFF, 16'h0000, 1'b0, 16'h0041};

        rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; instr_ready = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'b0001 : 4'($urandom_range(2, 15));
            mem[i] = {op, 12'($urandom)};
        end

        // Reset state and first stream
        mem[0] = 16'h0010; mem[1] = 16'h2000;
        fetch_en = 1'b1; instr_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("rst_mem_rd", 64'(mem_rd), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(RESET_PC));
        check("rst_valid", 64'(instr_valid), 64'(0));
        check("rst_bundle_zero", 64'({instr_word, instr_imm, instr_pc, instr_two_word}), 64'(0));
        tick(); rst_n = 1'b1;
        @(negedge clk); check("stream_issue0", 64'({mem_rd, mem_addr}), 64'({1'b1, 16'h0000}));
        tick();
        @(negedge clk); check("stream_issue1", 64'({mem_rd, mem_addr, instr_valid}), 64'({1'b1, 16'h0001, 1'b0}));
        tick();
        @(negedge clk); check("stream_bundle0", 64'({instr_valid, instr_pc, instr_word, instr_two_word}),
                              64'({1'b1, 16'h0000, 16'h0010, 1'b0}));
        tick();
        @(negedge clk); check("stream_bundle1", 64'({instr_valid, instr_pc, instr_word}),
                              64'({1'b1, 16'h0001, 16'h2000}));
        tick();

        // Pairing of ldi + immediate
        mem[0] = 16'h1010; mem[1] = 16'h000A; mem[2] = 16'h3000;
        reset_dut();
        tick(); tick(); tick();
        @(negedge clk); check("pair_bundle", 64'({instr_valid, instr_pc, instr_word, instr_imm, instr_two_word}),
                              64'({1'b1, 16'h0000, 16'h1010, 16'h000A, 1'b1}));
        tick();
        @(negedge clk); check("pair_next_pc", 64'({instr_valid, instr_pc}), 64'({1'b1, 16'h0002}));
        tick();

        // Backpressure: credit stops issue after four words
        instr_ready = 1'b0;
        reset_dut();
        nrd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            nrd += int'(mem_rd);
            tick();
        end
        check("bp_read_count", 64'(nrd), 64'(4));
        @(negedge clk); check("bp_rd_stopped", 64'(mem_rd), 64'(0));
        tick(); instr_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk); check("bp_resume", 64'(mem_rd), 64'(1));
        repeat (10) tick();

        // Redirect one cycle after issuing address 5
        reset_dut();
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (mem_rd && mem_addr == 16'd5) found = 1'b1;
            tick();
        end
        check("redir_addr5_seen", 64'(found), 64'(1));
        redirect = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk); check("redir_cycle_quiet", 64'({instr_valid, mem_rd}), 64'(0));
        tick(); redirect = 1'b0;
        @(negedge clk); check("redir_new_issue", 64'({mem_rd, mem_addr}), 64'({1'b1, 16'h0040}));
        wait_valid(ok);
        check("redir_first_valid", 64'(ok), 64'(1));
        check("redir_first_pc", 64'(instr_pc), 64'(16'h0040));
        tick();
        repeat (6) tick();

        // Mid-run reset for one clock
        rst_n = 1'b0;
        @(negedge clk); check("midrst_quiet", 64'({instr_valid, mem_rd}), 64'(0));
        tick(); rst_n = 1'b1;
        @(negedge clk); check("midrst_refetch", 64'({instr_valid, mem_rd, mem_addr}),
                              64'({1'b0, 1'b1, RESET_PC}));
        tick();

        // Table of redirect targets, including the 16'hFFFF wrap
        for (int r = 0; r < 6; r++) begin
            instr_ready = 1'b0; fetch_en = 1'b0;
            t1 = rows[r].target + 16'd1;
            mem[rows[r].target] = rows[r].w0;
            mem[t1] = rows[r].w1;
            redirect = 1'b1; redirect_pc = rows[r].target;
            tick();
            redirect = 1'b0; fetch_en = 1'b1;
            wait_valid(ok);
            check($sformatf("tbl%0d_valid", r), 64'(ok), 64'(1));
            check($sformatf("tbl%0d_bundle", r), 64'({instr_pc, instr_word, instr_imm, instr_two_word}),
                  64'({rows[r].target, rows[r].w0, rows[r].exp_imm, rows[r].exp_two}));
            tick(); instr_ready = 1'b1;
            @(negedge clk);
            tick(); instr_ready = 1'b0;
            wait_valid(ok);
            check($sformatf("tbl%0d_next_pc", r), 64'(instr_pc), 64'(rows[r].next_pc));
            tick();
        end

        // Randomized run against the scoreboard
        acc0 = n_accept;
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            fetch_en    = ($urandom_range(0, 7) != 0);
            redirect    = ($urandom_range(0, 39) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                                      : 16'($urandom);
            rst_n       = ($urandom_range(0, 299) != 0);
            tick();
        end
        redirect = 1'b0; rst_n = 1'b1;
        tick();
        check("random_progress", 64'(n_accept - acc0 > 500), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish before 1ms");
        $fatal(1, "timeout");
    end

endmodule
